cpu_v2_ldst_core: RTL and testbench
===================================

// Module: cpu_v2_ldst_core
// PURPOSE
//  Parametrised successor to the single-instruction cpu_v core: fetch/decode/execute FSM for AP9 data-movement ops.
//  Ops: NOP, HALT, LOAD, STORE, LOADN, LOADI, STOREI.
//  Internal register file; drives the shared RAM bus directly.
//  Sits between the FPGA top level and the on-chip RAM; ALU/branch units attach later.
// PARAMETERS
//  DATA_W    16  RAM word / register width; must be >= 16 (instruction = word[15:0])
//  ADDR_W    16  RAM address width; PC width
//  RAM_LAT   1   RAM read latency in cycles (>= 1)
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  wire_clock        in   1       single clock, all state on rising edge
//  wire_reset        in   1       synchronous, active-high reset
//  bus_RAM_ADDRESS   out  ADDR_W  RAM address
//  bus_RAM_DATA_OUT  in   DATA_W  read data from RAM
//  wire_RW           out  1       1 = write this cycle, 0 = read
//  bus_RAM_DATA_IN   out  DATA_W  write data to RAM
//  wire_instr_done   out  1       1-cycle pulse when an instruction retires
//  wire_illegal      out  1       1-cycle pulse on undefined opcode
//  wire_halted       out  1       high from HALT retire until reset
//  data_debug        out  DATA_W  see CONFIGURATION
// BEHAVIOUR
//  Decode: opcode = IR[15:10]; rx = IR[9:7]; ry = IR[6:4]; 8 regs R0..R7, DATA_W wide.
//    000000 NOP | 001111 HALT | 110000 LOAD rx<-M[next]
//    110001 STORE M[next]<-rx | 111000 LOADN rx<-next | 111100 LOADI rx<-M[Ry] | 111101 STOREI M[Ry]<-Rx
//    "next" = word at PC after fetch; PC advances past it.
//  Reset: PC=RESET_PC; IR=0; regs=0; all outputs 0; state=FETCH.
//  Reset asserted mid-instruction: wire_RW=0 at that edge; no write, no register update.
//  States: FETCH, FWAIT, DECODE, OPRD, OPWAIT, MRD, MWAIT, MWR, HALTED.
//  Read timing:
//    - 1 address cycle (bus_RAM_ADDRESS valid, wire_RW=0) + RAM_LAT wait cycles (down-counter).
//    - Data captured on the last wait cycle.
//    - Address held stable for the whole read.
//  Write timing: exactly one cycle with wire_RW=1; address and data valid that same cycle.
//    wire_RW=0 in every other cycle.
//  Fetch: FETCH (addr=PC) -> FWAIT (capture IR, PC<=PC+1) -> DECODE.
//  DECODE routing:
//    - NOP/illegal: retire.
//    - HALT: -> HALTED.
//    - LOAD/STORE/LOADN: -> OPRD (addr=PC; PC<=PC+1 at capture).
//    - LOADI: -> MRD (addr=Ry[ADDR_W-1:0]).
//    - STOREI: -> MWR (addr=Ry[ADDR_W-1:0], data=Rx).
//  After operand: LOAD -> MRD (addr=operand[ADDR_W-1:0]); STORE -> MWR (data=Rx); LOADN -> write Rx, retire.
//  Cycles per instruction, fetch through retire (L=RAM_LAT):
//    NOP 2+L | LOADN 3+2L | LOAD 4+3L | STORE 4+2L | LOADI 3+2L | STOREI 3+L
//  wire_instr_done: pulses in the retire cycle. Register write visible the cycle after.
//  Illegal opcode: wire_illegal and wire_instr_done pulse together; treated as NOP.
//  HALT: retires (done pulse), wire_halted=1; no further bus activity; PC frozen until reset.
//  PC wrap: (2^ADDR_W)-1 increments to 0, including a mid-instruction operand fetch.
//  Register index fields are 3 bits: all 8 regs are addressable; no out-of-range case.
//  STORE/STOREI of Rx sample Rx in the MWR cycle.
//  Store and next fetch never overlap: FETCH follows MWR.
// CONFIGURATION
//  CPU_V2_DEBUG_EN defined:
//    - data_debug = last value written to any register; updates the cycle after the write.
//    - Reset value 0.
//  CPU_V2_DEBUG_EN undefined: data_debug tied to 0; no extra flops.
// TESTING
//  1 Reset, L=1, RAM[0]=0xE080 (LOADN R1), RAM[1]=0x1234 -> done pulse at cycle 5; R1=0x1234; PC=2.
//  2 LOAD R2 from 0x0040 (=0xBEEF), then STORE R2 to 0x0050
//    -> LOAD retires in 7 cycles; one wire_RW=1 cycle with addr 0x0050, data 0xBEEF; STORE retires in 6.
//  3 RAM_LAT=3, R3=0x0040, LOADI R4,[R3] -> address held 4 cycles; R4=0xBEEF; done at 3+2*3=9 cycles.
//  4 Opcode 0x2400 -> wire_illegal and done pulse same cycle; next fetch at PC+1; regs unchanged.
//  5 HALT (0x3C00) -> wire_halted=1; bus idle 100 cycles; reset -> halted=0, fetch from RESET_PC.
//  6 Reset asserted in a STORE's MWR cycle -> wire_RW=0, RAM untouched.
//    Also: LOADN at PC=0xFFFF -> operand read from 0x0000, PC=0x0001.

Source files
------------

// File: rtl/cpu_v2_ldst_core.sv
`default_nettype none
// ============================================================================
// Module   : cpu_v2_ldst_core
// Purpose  : Fetch/decode/execute FSM for AP9 data-movement ops (NOP, HALT,
//            LOAD, STORE, LOADN, LOADI, STOREI) with an 8-entry register file,
//            driving the shared RAM bus directly. Assumes ADDR_W <= DATA_W.
//            Optional feature macro: CPU_V2_DEBUG_EN (last register write on
//            data_debug).
// Revision : 1.0 - initial release
// ============================================================================
module cpu_v2_ldst_core #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int RAM_LAT  = 1,
    parameter int RESET_PC = 0
) (
    input  logic              wire_clock,
    input  logic              wire_reset,
    output logic [ADDR_W-1:0] bus_RAM_ADDRESS,
    input  logic [DATA_W-1:0] bus_RAM_DATA_OUT,
    output logic              wire_RW,
    output logic [DATA_W-1:0] bus_RAM_DATA_IN,
    output logic              wire_instr_done,
    output logic              wire_illegal,
    output logic              wire_halted,
    output logic [DATA_W-1:0] data_debug
);

    localparam logic [5:0] c_OP_NOP    = 6'b000000;
    localparam logic [5:0] c_OP_HALT   = 6'b001111;
    localparam logic [5:0] c_OP_LOAD   = 6'b110000;
    localparam logic [5:0] c_OP_STORE  = 6'b110001;
    localparam logic [5:0] c_OP_LOADN  = 6'b111000;
    localparam logic [5:0] c_OP_LOADI  = 6'b111100;
    localparam logic [5:0] c_OP_STOREI = 6'b111101;

    localparam logic [3:0] c_S_FETCH  = 4'd0;
    localparam logic [3:0] c_S_FWAIT  = 4'd1;
    localparam logic [3:0] c_S_DECODE = 4'd2;
    localparam logic [3:0] c_S_OPRD   = 4'd3;
    localparam logic [3:0] c_S_OPWAIT = 4'd4;
    localparam logic [3:0] c_S_MRD    = 4'd5;
    localparam logic [3:0] c_S_MWAIT  = 4'd6;
    localparam logic [3:0] c_S_MWR    = 4'd7;
    localparam logic [3:0] c_S_HALTED = 4'd8;

    localparam int                 c_CNT_W     = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_INIT = c_CNT_W'(RAM_LAT - 1);

    logic [3:0]         r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [15:0]        r_ir;
    logic [DATA_W-1:0]  r_regs [8];
    logic [ADDR_W-1:0]  r_maddr;
    logic [c_CNT_W-1:0] r_wait;

    logic [3:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_addr;
    logic              w_rw;
    logic [DATA_W-1:0] w_din;
    logic              w_done;
    logic              w_ill;
    logic              w_reg_we;
    logic [DATA_W-1:0] w_reg_wdata;
    logic              w_ir_we;
    logic              w_pc_inc;
    logic              w_maddr_we;
    logic [ADDR_W-1:0] w_maddr_d;
    logic              w_wait_load;

    logic [5:0]        w_op;
    logic [DATA_W-1:0] w_rx_val;
    logic [DATA_W-1:0] w_ry_val;
    logic              w_last;
    logic              w_unused;

    assign w_op     = r_ir[15:10];
    assign w_rx_val = r_regs[r_ir[9:7]];
    assign w_ry_val = r_regs[r_ir[6:4]];
    assign w_last   = (r_wait == '0);
    assign w_unused = &{1'b0, r_ir[3:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_addr      = '0;
        w_rw        = 1'b0;
        w_din       = '0;
        w_done      = 1'b0;
        w_ill       = 1'b0;
        w_reg_we    = 1'b0;
        w_reg_wdata = '0;
        w_ir_we     = 1'b0;
        w_pc_inc    = 1'b0;
        w_maddr_we  = 1'b0;
        w_maddr_d   = '0;
        w_wait_load = 1'b0;
        case (r_state)
            c_S_FETCH: begin
                w_addr      = r_pc;
                w_wait_load = 1'b1;
                w_state_nxt = c_S_FWAIT;
            end
            c_S_FWAIT: begin
                w_addr = r_pc;
                if (w_last) begin
                    w_ir_we     = 1'b1;
                    w_pc_inc    = 1'b1;
                    w_state_nxt = c_S_DECODE;
                end
            end
            c_S_DECODE: begin
                case (w_op)
                    c_OP_NOP: begin
                        w_done      = 1'b1;
                        w_state_nxt = c_S_FETCH;
                    end
                    c_OP_HALT: begin
                        w_done      = 1'b1;
                        w_state_nxt = c_S_HALTED;
                    end
                    c_OP_LOAD, c_OP_STORE, c_OP_LOADN: w_state_nxt = c_S_OPRD;
                    c_OP_LOADI: begin
                        w_maddr_we  = 1'b1;
                        w_maddr_d   = w_ry_val[ADDR_W-1:0];
                        w_state_nxt = c_S_MRD;
                    end
                    c_OP_STOREI: begin
                        w_maddr_we  = 1'b1;
                        w_maddr_d   = w_ry_val[ADDR_W-1:0];
                        w_state_nxt = c_S_MWR;
                    end
                    default: begin
                        w_done      = 1'b1;
                        w_ill       = 1'b1;
                        w_state_nxt = c_S_FETCH;
                    end
                endcase
            end
            c_S_OPRD: begin
                w_addr      = r_pc;
                w_wait_load = 1'b1;
                w_state_nxt = c_S_OPWAIT;
            end
            c_S_OPWAIT: begin
                w_addr = r_pc;
                if (w_last) begin
                    w_pc_inc  = 1'b1;
                    w_maddr_d = bus_RAM_DATA_OUT[ADDR_W-1:0];
                    case (w_op)
                        c_OP_LOAD: begin
                            w_maddr_we  = 1'b1;
                            w_state_nxt = c_S_MRD;
                        end
                        c_OP_STORE: begin
                            w_maddr_we  = 1'b1;
                            w_state_nxt = c_S_MWR;
                        end
                        default: begin
                            // LOADN: the operand word itself is the value
                            w_reg_we    = 1'b1;
                            w_reg_wdata = bus_RAM_DATA_OUT;
                            w_done      = 1'b1;
                            w_state_nxt = c_S_FETCH;
                        end
                    endcase
                end
            end
            c_S_MRD: begin
                w_addr      = r_maddr;
                w_wait_load = 1'b1;
                w_state_nxt = c_S_MWAIT;
            end
            c_S_MWAIT: begin
                w_addr = r_maddr;
                if (w_last) begin
                    w_reg_we    = 1'b1;
                    w_reg_wdata = bus_RAM_DATA_OUT;
                    w_done      = 1'b1;
                    w_state_nxt = c_S_FETCH;
                end
            end
            c_S_MWR: begin
                w_addr      = r_maddr;
                w_rw        = 1'b1;
                w_din       = w_rx_val;
                w_done      = 1'b1;
                w_state_nxt = c_S_FETCH;
            end
            c_S_HALTED: w_state_nxt = c_S_HALTED;
            default:    w_state_nxt = c_S_FETCH;
        endcase
    end

    always_ff @(posedge wire_clock) begin
        if (wire_reset) begin
            r_state <= c_S_FETCH;
            r_pc    <= ADDR_W'(RESET_PC);
            r_ir    <= '0;
            r_maddr <= '0;
            r_wait  <= '0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_ir_we) begin
                r_ir <= bus_RAM_DATA_OUT[15:0];
            end
            if (w_pc_inc) begin
                r_pc <= r_pc + 1'b1;
            end
            if (w_maddr_we) begin
                r_maddr <= w_maddr_d;
            end
            if (w_wait_load) begin
                r_wait <= c_WAIT_INIT;
            end else if (r_wait != '0) begin
                r_wait <= r_wait - 1'b1;
            end
            if (w_reg_we) begin
                r_regs[r_ir[9:7]] <= w_reg_wdata;
            end
        end
    end

    // Outputs are forced idle while reset is held so a store cut by reset never reaches RAM
    assign bus_RAM_ADDRESS = wire_reset ? '0 : w_addr;
    assign wire_RW         = w_rw & ~wire_reset;
    assign bus_RAM_DATA_IN = wire_reset ? '0 : w_din;
    assign wire_instr_done = w_done & ~wire_reset;
    assign wire_illegal    = w_ill & ~wire_reset;
    assign wire_halted     = (r_state == c_S_HALTED) & ~wire_reset;

`ifdef CPU_V2_DEBUG_EN
    logic [DATA_W-1:0] r_debug;

    always_ff @(posedge wire_clock) begin
        if (wire_reset) begin
            r_debug <= '0;
        end else if (w_reg_we) begin
            r_debug <= w_reg_wdata;
        end
    end

    assign data_debug = wire_reset ? '0 : r_debug;
`else
    assign data_debug = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_v2_ldst_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_v2_ldst_core
// Purpose  : Scoreboard bench; DUT A (RAM_LAT=1, RESET_PC=0xFFFF) runs a
//            data-movement program, DUT B (RAM_LAT=3) covers the slow-RAM case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_v2_ldst_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    logic [15:0] addr_a, dout_a, din_a, dbg_a;
    logic        rw_a, done_a, ill_a, halt_a;
    logic [15:0] addr_b, dout_b, din_b, dbg_b;
    logic        rw_b, done_b, ill_b, halt_b;

    cpu_v2_ldst_core #(.DATA_W(16), .ADDR_W(16), .RAM_LAT(1), .RESET_PC(16'hFFFF)) dut_a (
        .wire_clock(clk), .wire_reset(rst_a),
        .bus_RAM_ADDRESS(addr_a), .bus_RAM_DATA_OUT(dout_a), .wire_RW(rw_a),
        .bus_RAM_DATA_IN(din_a), .wire_instr_done(done_a), .wire_illegal(ill_a),
        .wire_halted(halt_a), .data_debug(dbg_a)
    );

    cpu_v2_ldst_core #(.DATA_W(16), .ADDR_W(16), .RAM_LAT(3), .RESET_PC(0)) dut_b (
        .wire_clock(clk), .wire_reset(rst_b),
        .bus_RAM_ADDRESS(addr_b), .bus_RAM_DATA_OUT(dout_b), .wire_RW(rw_b),
        .bus_RAM_DATA_IN(din_b), .wire_instr_done(done_b), .wire_illegal(ill_b),
        .wire_halted(halt_b), .data_debug(dbg_b)
    );

    // RAM models: read data appears RAM_LAT cycles after the address
    logic [15:0] mem_a [65536];
    logic [15:0] mem_b [65536];
    logic [15:0] pa;
    logic [15:0] pb [3];
    logic        pk_en = 1'b0;
    logic        pk_sel = 1'b0;
    logic [15:0] pk_addr = '0;
    logic [15:0] pk_data = '0;

    always @(posedge clk) begin
        if (pk_en && !pk_sel) mem_a[pk_addr] <= pk_data;
        else if (rw_a)        mem_a[addr_a]  <= din_a;
        if (pk_en && pk_sel)  mem_b[pk_addr] <= pk_data;
        else if (rw_b)        mem_b[addr_b]  <= din_b;
        pa    <= mem_a[addr_a];
        pb[0] <= mem_b[addr_b];
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign dout_a = pa;
    assign dout_b = pb[2];

    typedef struct { int cyc; bit ill; } done_t;
    typedef struct { int cyc; logic [15:0] a; logic [15:0] d; } wr_t;
    done_t done_q[$];
    wr_t   wr_q[$];

    int checks = 0;
    int errors = 0;

    logic [15:0] addr_log [0:199];
    logic [15:0] s_addr, s_din, s_dbg;
    logic        s_rw, s_done, s_ill, s_halt;

    task automatic step(input bit sel);
        @(negedge clk);
        if (!sel) begin
            s_addr = addr_a; s_din = din_a; s_dbg = dbg_a;
            s_rw = rw_a; s_done = done_a; s_ill = ill_a; s_halt = halt_a;
        end else begin
            s_addr = addr_b; s_din = din_b; s_dbg = dbg_b;
            s_rw = rw_b; s_done = done_b; s_ill = ill_b; s_halt = halt_b;
        end
    endtask

    task automatic poke(input bit sel, input logic [15:0] a, input logic [15:0] d);
        pk_sel = sel; pk_addr = a; pk_data = d; pk_en = 1'b1;
        @(posedge clk);
        #1 pk_en = 1'b0;
    endtask

    task automatic release_rst(input bit sel);
        @(posedge clk);
        #1;
        if (!sel) rst_a = 1'b0;
        else      rst_b = 1'b0;
    endtask

    task automatic push_done(input int cyc, input bit ill);
        done_t e;
        e.cyc = cyc; e.ill = ill;
        done_q.push_back(e);
    endtask

    task automatic push_wr(input int cyc, input logic [15:0] a, input logic [15:0] d);
        wr_t e;
        e.cyc = cyc; e.a = a; e.d = d;
        wr_q.push_back(e);
    endtask

    // Cycle n = n-th clock period after reset release; compares retires and writes against the queues
    task automatic run_prog(input bit sel, input int first, input int last);
        done_t ed;
        wr_t   ew;
        for (int n = first; n <= last; n++) begin
            step(sel);
            addr_log[n] = s_addr;
            if (s_done) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL retire: unexpected done at cycle %0d", n);
                end else begin
                    ed = done_q.pop_front();
                    if (n !== ed.cyc || s_ill !== ed.ill) begin
                        errors++;
                        $display("FAIL retire: got cycle %0d illegal %0b, expected cycle %0d illegal %0b",
                                 n, s_ill, ed.cyc, ed.ill);
                    end
                end
            end else if (s_ill) begin
                checks++; errors++;
                $display("FAIL illegal_alone: illegal without done at cycle %0d", n);
            end
            if (s_rw) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL write: unexpected write cycle %0d addr %h data %h", n, s_addr, s_din);
                end else begin
                    ew = wr_q.pop_front();
                    if (n !== ew.cyc || s_addr !== ew.a || s_din !== ew.d) begin
                        errors++;
                        $display("FAIL write: got cycle %0d addr %h data %h, expected cycle %0d addr %h data %h",
                                 n, s_addr, s_din, ew.cyc, ew.a, ew.d);
                    end
                end
            end
        end
        checks++;
        if (done_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL pending: %0d retires and %0d writes not seen by cycle %0d, expected 0 and 0",
                     done_q.size(), wr_q.size(), last);
        end
        done_q.delete();
        wr_q.delete();
    endtask

    task automatic check_addr(input string name, input int n, input logic [15:0] exp);
        checks++;
        if (addr_log[n] !== exp) begin
            errors++;
            $display("FAIL %s: address in cycle %0d is %h, expected %h", name, n, addr_log[n], exp);
        end
    endtask

    task automatic check_idle_outputs(input string name, input bit sel);
        step(sel);
        checks++;
        if ({s_addr, s_din, s_dbg, s_rw, s_done, s_ill, s_halt} !== '0) begin
            errors++;
            $display("FAIL %s: addr %h din %h dbg %h rw %b done %b ill %b halt %b, expected all 0",
                     name, s_addr, s_din, s_dbg, s_rw, s_done, s_ill, s_halt);
        end
    endtask

    task automatic test_reset();
        // Program A starts at 0xFFFF so the LOADN operand wraps to 0x0000
        poke(0, 16'hFFFF, 16'hE080); poke(0, 16'h0000, 16'h1234);
        poke(0, 16'h0001, 16'hC100); poke(0, 16'h0002, 16'h0040);
        poke(0, 16'h0003, 16'hC500); poke(0, 16'h0004, 16'h0050);
        poke(0, 16'h0005, 16'h2400);
        poke(0, 16'h0006, 16'hC480); poke(0, 16'h0007, 16'h0051);
        poke(0, 16'h0008, 16'hF510); poke(0, 16'h0009, 16'hF190);
        poke(0, 16'h000A, 16'hC580); poke(0, 16'h000B, 16'h0052);
        poke(0, 16'h000C, 16'h0000); poke(0, 16'h000D, 16'h3C00);
        poke(0, 16'h0040, 16'hBEEF);
        poke(1, 16'h0000, 16'hE180); poke(1, 16'h0001, 16'h0040);
        poke(1, 16'h0002, 16'hF230);
        poke(1, 16'h0003, 16'hC600); poke(1, 16'h0004, 16'h0060);
        poke(1, 16'h0005, 16'h3C00);
        poke(1, 16'h0040, 16'hBEEF);
        check_idle_outputs("reset_a", 0);
        check_idle_outputs("reset_b", 1);
    endtask

    task automatic test_loadn_wrap();
        push_done(5, 0);
        release_rst(0);
        run_prog(0, 1, 6);
        check_addr("fetch_reset_pc", 1, 16'hFFFF);
        check_addr("operand_wrap", 4, 16'h0000);
        check_addr("pc_after_loadn", 6, 16'h0001);
    endtask

    task automatic test_load_store();
        push_done(12, 0); push_done(18, 0);
        push_wr(18, 16'h0050, 16'hBEEF);
        run_prog(0, 7, 18);
        check_addr("load_addr_first", 11, 16'h0040);
        check_addr("load_addr_held", 12, 16'h0040);
    endtask

    task automatic test_illegal();
        push_done(21, 1); push_done(27, 0);
        push_wr(27, 16'h0051, 16'h1234);
        run_prog(0, 19, 27);
        check_addr("fetch_after_illegal", 22, 16'h0006);
    endtask

    task automatic test_back_to_back();
        push_done(31, 0); push_done(36, 0); push_done(42, 0); push_done(45, 0);
        push_wr(31, 16'h1234, 16'hBEEF);
        push_wr(42, 16'h0052, 16'hBEEF);
        run_prog(0, 28, 45);
    endtask

    task automatic test_halt();
        int activity;
        push_done(48, 0);
        run_prog(0, 46, 48);
        step(0);
        checks++;
        if (s_halt !== 1'b1) begin
            errors++;
            $display("FAIL halted_set: halted %b, expected 1", s_halt);
        end
        activity = 0;
        for (int i = 0; i < 100; i++) begin
            step(0);
            if (s_rw || s_done || s_ill || s_addr != 16'h0 || !s_halt) activity++;
        end
        checks++;
        if (activity != 0) begin
            errors++;
            $display("FAIL halt_idle: %0d active cycles, expected 0", activity);
        end
        @(posedge clk);
        #1 rst_a = 1'b1;
        check_idle_outputs("reset_from_halt", 0);
        poke(0, 16'h0050, 16'hA5A5);
        release_rst(0);
        run_prog(0, 1, 1);
        check_addr("refetch_reset_pc", 1, 16'hFFFF);
        checks++;
        if (s_halt !== 1'b0) begin
            errors++;
            $display("FAIL halted_clear: halted %b, expected 0", s_halt);
        end
    endtask

    task automatic test_reset_in_store();
        push_done(5, 0); push_done(12, 0);
        run_prog(0, 2, 17);
        @(posedge clk);
        #1 rst_a = 1'b1;
        step(0);
        checks++;
        if (s_rw !== 1'b0 || s_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_mwr: rw %b done %b, expected 0 0", s_rw, s_done);
        end
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (mem_a[16'h0050] !== 16'hA5A5) begin
            errors++;
            $display("FAIL ram_untouched: RAM[0050] %h, expected a5a5", mem_a[16'h0050]);
        end
    endtask

    task automatic test_lat3();
        int held;
        push_done(9, 0); push_done(18, 0); push_done(28, 0); push_done(33, 0);
        push_wr(28, 16'h0060, 16'hBEEF);
        release_rst(1);
        run_prog(1, 1, 40);
        held = 0;
        for (int n = 1; n <= 40; n++) begin
            if (addr_log[n] == 16'h0040) held++;
        end
        checks++;
        if (held != 4) begin
            errors++;
            $display("FAIL loadi_hold: address 0040 seen %0d cycles, expected 4", held);
        end
        check_addr("loadi_addr_start", 15, 16'h0040);
        check_addr("loadi_addr_end", 18, 16'h0040);
        step(1);
        checks++;
        if (s_halt !== 1'b1) begin
            errors++;
            $display("FAIL halted_b: halted %b, expected 1", s_halt);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_loadn_wrap();
        test_load_store();
        test_illegal();
        test_back_to_back();
        test_halt();
        test_reset_in_store();
        test_lat3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
